// File: rtl/basys3_pkg.sv
// rtl/basys3_pkg.sv - shared constants for the Basys3 serial adder datapath
package basys3_pkg;

  // Default operand width used by the board-level build
  localparam int SERIAL_ADDER_WIDTH = 8;

  typedef logic [1:0] sa_state_t;

  // FSM encoding; 2'd3 is unused and recovers to IDLE
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - single-bit full adder cell used as the serial datapath slice
module FullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  // Classic sum/majority full adder
  always_comb begin
    S    = A ^ B ^ Cin;
    Cout = (A & B) | (A & Cin) | (B & Cin);
  end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder driving one FullAdder cell, LSB first
module serial_adder
  import basys3_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  // Counter only needs to reach WIDTH-1; keep at least one bit for WIDTH=1
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] rega_q, rega_d;
  logic [WIDTH-1:0] regb_q, regb_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH:0]   psum_cat;

  FullAdder u_fa (
    .A    (rega_q[0]),
    .B    (regb_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // New sum bit enters at the MSB; upper WIDTH bits of the concatenation are the shifted register
  assign psum_cat = {fa_s, psum_q};

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence
  always_comb begin
    state_d = state_q;
    rega_d  = rega_q;
    regb_d  = regb_q;
    psum_d  = psum_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          rega_d  = A;
          regb_d  = B;
          carry_d = Cin;
          cnt_d   = '0;
          psum_d  = '0;
        end
      end
      ST_SHIFT: begin
        rega_d  = rega_q >> 1;
        regb_d  = regb_q >> 1;
        psum_d  = psum_cat[WIDTH:1];
        carry_d = fa_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
          s_d     = psum_cat[WIDTH:1];
          cout_d  = fa_cout;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous abort-to-idle reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rega_q  <= '0;
      regb_q  <= '0;
      psum_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rega_q  <= rega_d;
      regb_q  <= regb_d;
      psum_q  <= psum_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);
  assign S    = s_q;
  assign Cout = cout_q;

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial N-bit adder that sits directly upstream of, and drives, the existing single-bit FullAdder cell. It captures two operands and a carry-in on a start strobe. It then feeds the FullAdder one bit pair per clock, LSB first, and keeps the carry in a flip-flop between cycles. The assembled sum and final carry are presented with a one-cycle done pulse, for display on the Basys3 LEDs and seven-segment path.

Parameters:
WIDTH, 8, operand and sum width in bits (legal range 1..32)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to begin an addition; sampled only in IDLE
A  input  WIDTH  operand A, captured when start is accepted
B  input  WIDTH  operand B, captured when start is accepted
Cin  input  1  carry-in, captured when start is accepted
busy  output  1  high while an addition is in progress (state != IDLE)
done  output  1  one-cycle pulse when S/Cout become valid
S  output  WIDTH  registered sum; holds until the next completion
Cout  output  1  registered final carry-out; holds until the next completion

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset: state=IDLE. busy=0, done=0, S=0, Cout=0. Operand shift registers, carry flop and bit counter are cleared.
- FSM states:
  - IDLE: waits for start.
  - SHIFT: one bit per cycle.
  - DONE: single-cycle completion state.
- IDLE -> SHIFT on start=1 at edge k:
  - regA<=A, regB<=B, carry<=Cin, cnt<=0, partial sum register cleared.
- SHIFT, each edge:
  - FullAdder inputs are regA[0], regB[0], carry.
  - Its S output shifts into the MSB of the partial sum register; the register shifts right.
  - regA and regB shift right with zero fill.
  - carry<=FullAdder Cout; cnt<=cnt+1.
- SHIFT -> DONE at the edge where cnt==WIDTH-1, which is the WIDTH-th shift (edge k+WIDTH).
  - The same edge loads the output registers: S<=completed sum, Cout<=last FullAdder Cout.
- DONE -> IDLE unconditionally on the next edge. done=1 only while in DONE.
- Latency: start accepted at edge k gives done=1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles from the start edge.
- busy: high from edge k through the DONE cycle inclusive.
- Arithmetic: {Cout,S} = A + B + Cin, computed modulo 2^(WIDTH+1). There is no overflow flag.
- start while busy (SHIFT or DONE): ignored, not queued. A/B/Cin changes during SHIFT have no effect.
- Back-to-back operation: start held high continuously is accepted in the IDLE cycle after DONE, so additions run at one result per WIDTH+2 cycles.
- S/Cout: change only at completion and hold stable otherwise, including through IDLE.
- Reset mid-operation: abort immediately to IDLE. All outputs go to zero, and no done pulse is issued for the aborted operation.
- WIDTH=1: a single SHIFT cycle; must equal the FullAdder truth table.
- cnt width: $clog2(WIDTH) bits, minimum 1. cnt must not wrap before the terminal compare.

Decomposition:
- Shared package (basys3_pkg):
  - FSM state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2, where 2'd3 is illegal and recovers to IDLE.
  - SERIAL_ADDER_WIDTH default constant.
- One sub-module instance: the existing FullAdder (ports A, B, Cin, S, Cout), instantiated once as the datapath bit-slice. No other sub-modules.

Test Plan:
- Reset then WIDTH=8, A=0x00, B=0x00, Cin=0, start pulse:
  - done exactly 9 cycles after the start edge.
  - S=0x00, Cout=0.
  - busy high for 9 cycles.
- A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1.
- A=0xA5, B=0x5A, Cin=1 -> S=0x00, Cout=1.
- A=0x3C, B=0x0F, Cin=0 -> S=0x4B, Cout=0.
  - Then pulse start with A=0x01, B=0x01 at cycle 3 of SHIFT: ignored, and S stays 0x4B.
- Start A=0x80, B=0x80, Cin=0, then assert reset at cycle 4 of SHIFT:
  - Next cycle busy=0, S=0x00, Cout=0, and no done pulse.
  - A fresh start then gives S=0x00, Cout=1.
- WIDTH=1 build, all 8 {A,B,Cin} combinations -> {Cout,S} equals 00,01,01,10,01,10,10,11 in order, with done 2 cycles after each start.
